// File: rtl/i2c_pkg.sv
// Shared types for the I2C init sequencer: FSM states and
// the command table entry layout.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_PULSE     = 4'd2,
    S_WAIT_BUSY = 4'd3,
    S_WAIT_DONE = 4'd4,
    S_CHECK     = 4'd5,
    S_FAIL      = 4'd6,
    S_GAP       = 4'd7,
    S_DONE      = 4'd8,
    S_ERROR     = 4'd9
  } state_e;

  typedef struct packed {
    logic [7:0]  dev_addr;
    logic [15:0] reg_data;
  } cmd_t;

endpackage

// File: rtl/i2c_init_sequencer.sv
// Walks a {dev_addr, reg_data} table and issues one i2c_master
// write per entry, retrying on NACK or timeout.
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int NUM_CMDS    = 16,
  parameter int IDX_W       = 4,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic [IDX_W-1:0] tbl_index,
  input  logic [7:0]       tbl_dev_addr,
  input  logic [15:0]      tbl_reg_data,
  output logic             m_start,
  output logic [7:0]       m_dev_address,
  output logic [15:0]      m_reg_data,
  input  logic             m_finish,
  input  logic             m_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] eidx_q, eidx_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  cmd_t             cmd_q, cmd_d;
  logic             ack_q, ack_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             expired;
  logic [TW-1:0]    timer_inc;

  // Timer saturates so a stuck master cannot wrap it back to zero.
  assign expired   = (timer_q == TW'(TIMEOUT_CYC));
  assign timer_inc = expired ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    eidx_d  = eidx_q;
    retry_d = retry_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    cmd_d   = cmd_q;
    ack_d   = ack_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          state_d = S_LOAD;
          idx_d   = '0;
          eidx_d  = '0;
          retry_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      S_LOAD: begin
        cmd_d   = '{dev_addr: tbl_dev_addr,
                    reg_data: tbl_reg_data};
        timer_d = '0;
        start_d = 1'b1;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        timer_d = timer_inc;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        timer_d = timer_inc;
        if (!m_finish)    state_d = S_WAIT_DONE;
        else if (expired) state_d = S_FAIL;
      end
      S_WAIT_DONE: begin
        timer_d = timer_inc;
        // Master drops ack one cycle after finish rises.
        if (m_finish) begin
          ack_d   = m_ack;
          state_d = S_CHECK;
        end else if (expired) begin
          state_d = S_FAIL;
        end
      end
      S_CHECK: begin
        if (!ack_q) begin
          state_d = S_FAIL;
        end else if (idx_q == IDX_W'(NUM_CMDS - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + 1'b1;
          retry_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_FAIL: begin
        if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          error_d = 1'b1;
          eidx_d  = idx_q;
          busy_d  = 1'b0;
          state_d = S_ERROR;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) state_d = S_LOAD;
        else                           gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      eidx_q  <= '0;
      retry_q <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      cmd_q   <= '0;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      eidx_q  <= eidx_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign tbl_index     = idx_q;
  assign m_start       = start_q;
  assign m_dev_address = cmd_q.dev_addr;
  assign m_reg_data    = cmd_q.reg_data;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_index     = eidx_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: behavioural master/slave model,
// random command table and an attempt-list reference model.
module tb_i2c_init_sequencer;
  import i2c_pkg::*;

  localparam int NCMD = 3;
  localparam int MAXR = 3;
  localparam int TOUT = 64;
  localparam int GAP  = 4;
  localparam int NEVER = 99;

  typedef struct {
    int          idx;
    logic [7:0]  a;
    logic [15:0] d;
  } obs_t;

  logic        clk = 0;
  logic        reset = 1;
  logic        go = 0;
  logic [3:0]  tbl_index;
  logic [7:0]  tbl_dev_addr;
  logic [15:0] tbl_reg_data;
  logic        m_start;
  logic [7:0]  m_dev_address;
  logic [15:0] m_reg_data;
  logic        m_finish;
  logic        m_ack;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  err_index;

  cmd_t tbl [16];
  int   plan [NCMD];
  bit   disconnected = 0;
  obs_t obs [$];
  int   exp_q [$];
  bit   exp_err;
  int   exp_eidx;
  int   checks = 0;
  int   failures = 0;

  assign tbl_dev_addr = tbl[tbl_index].dev_addr;
  assign tbl_reg_data = tbl[tbl_index].reg_data;

  i2c_init_sequencer #(
    .NUM_CMDS(NCMD), .IDX_W(4), .MAX_RETRY(MAXR),
    .TIMEOUT_CYC(TOUT), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .tbl_index(tbl_index),
    .tbl_dev_addr(tbl_dev_addr),
    .tbl_reg_data(tbl_reg_data),
    .m_start(m_start),
    .m_dev_address(m_dev_address),
    .m_reg_data(m_reg_data),
    .m_finish(m_finish), .m_ack(m_ack),
    .busy(busy), .done(done), .error(error),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  // Every start pulse seen is one attempt.
  always @(negedge clk)
    if (!reset && m_start)
      obs.push_back('{int'(tbl_index), m_dev_address, m_reg_data});

  function automatic int attempts_of(int idx);
    int n = 0;
    foreach (obs[i]) if (obs[i].idx == idx) n++;
    return n;
  endfunction

  // Master + slave: acks once an entry has had more than plan[] attempts.
  logic prev_start;
  logic active;
  int   cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_finish   <= 1'b1;
      m_ack      <= 1'b0;
      prev_start <= 1'b0;
      active     <= 1'b0;
      cnt        <= 0;
    end else begin
      prev_start <= m_start;
      m_ack      <= 1'b0;
      if (disconnected) begin
        m_finish <= 1'b1;
        active   <= 1'b0;
      end else if (active) begin
        if (cnt == 0) begin
          active   <= 1'b0;
          m_finish <= 1'b1;
          m_ack    <= attempts_of(int'(tbl_index))
                      > plan[int'(tbl_index)];
        end else begin
          cnt <= cnt - 1;
        end
      end else if (prev_start && !m_start) begin
        active   <= 1'b1;
        m_finish <= 1'b0;
        cnt      <= int'($urandom_range(2, 8));
      end
    end
  end

  task automatic build_exp();
    exp_q.delete();
    exp_err  = 0;
    exp_eidx = 0;
    for (int i = 0; i < NCMD; i++) begin
      int n = (plan[i] > MAXR) ? MAXR + 1 : plan[i] + 1;
      repeat (n) exp_q.push_back(i);
      if (plan[i] > MAXR) begin
        exp_err  = 1;
        exp_eidx = i;
        break;
      end
    end
  endtask

  task automatic rand_table();
    for (int i = 0; i < 16; i++) begin
      tbl[i].dev_addr = 8'($urandom);
      tbl[i].reg_data = 16'($urandom);
    end
  endtask

  task automatic set_plan(int p0, int p1, int p2);
    plan[0] = p0;
    plan[1] = p1;
    plan[2] = p2;
  endtask

  task automatic do_run(input int budget, output bit to);
    obs.delete();
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    to = 1;
    for (int k = 0; k < budget; k++) begin
      if (!busy) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    #1;
    checks++;
    if ({m_start, m_dev_address, m_reg_data, busy, done,
         error, err_index, tbl_index} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %0h want 0",
        {m_start, m_dev_address, m_reg_data, busy, done,
         error, err_index, tbl_index});
    end
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_all_ack();
    bit to;
    rand_table();
    set_plan(0, 0, 0);
    build_exp();
    obs.delete();
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL all_ack_busy got %b want 1", busy);
    end
    to = 1;
    for (int k = 0; k < 2000; k++) begin
      if (!busy) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (to) begin
      failures++;
      $display("FAIL all_ack_timeout got busy want idle");
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL all_ack_pulses got %0d want %0d",
        obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs.size() || obs[i].idx != exp_q[i] ||
          obs[i].a !== tbl[exp_q[i]].dev_addr ||
          obs[i].d !== tbl[exp_q[i]].reg_data) begin
        failures++;
        $display("FAIL all_ack_cmd%0d got idx%0d %h/%h want idx%0d",
          i, (i < obs.size()) ? obs[i].idx : -1,
          (i < obs.size()) ? obs[i].a : 8'h0,
          (i < obs.size()) ? obs[i].d : 16'h0, exp_q[i]);
      end
    end
    checks++;
    if ({done, error, busy} !== 3'b100) begin
      failures++;
      $display("FAIL all_ack_flags got d%b e%b b%b want d1 e0 b0",
        done, error, busy);
    end
  endtask

  task automatic test_scenario(string name, int p0, int p1,
                               int p2, bit disc);
    bit to;
    rand_table();
    set_plan(p0, p1, p2);
    disconnected = disc;
    build_exp();
    do_run(4000, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL %s_timeout got busy want idle", name);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_pulses got %0d want %0d",
        name, obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs.size() || obs[i].idx != exp_q[i] ||
          obs[i].a !== tbl[exp_q[i]].dev_addr ||
          obs[i].d !== tbl[exp_q[i]].reg_data) begin
        failures++;
        $display("FAIL %s_cmd%0d got idx%0d want idx%0d",
          name, i, (i < obs.size()) ? obs[i].idx : -1, exp_q[i]);
      end
    end
    checks++;
    if ({done, error, busy} !== {!exp_err, exp_err, 1'b0} ||
        (exp_err && err_index !== 4'(exp_eidx))) begin
      failures++;
      $display("FAIL %s_flags got d%b e%b b%b ei%0d want d%b e%b b0 ei%0d",
        name, done, error, busy, err_index,
        !exp_err, exp_err, exp_eidx);
    end
    disconnected = 0;
  endtask

  task automatic test_reset_mid_run();
    bit hit;
    bit to;
    rand_table();
    set_plan(0, 0, 0);
    obs.delete();
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    hit = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (obs.size() >= 2 && !m_finish) begin
        hit = 1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!hit || tbl_index !== 4'd1) begin
      failures++;
      $display("FAIL rst_mid_reach got hit%b idx%0d want hit1 idx1",
        hit, tbl_index);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({m_start, m_dev_address, m_reg_data, busy, done,
         error, err_index, tbl_index} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got %0h want 0",
        {m_start, m_dev_address, m_reg_data, busy, done,
         error, err_index, tbl_index});
    end
    @(negedge clk) reset = 0;
    build_exp();
    do_run(2000, to);
    checks++;
    if (to || obs.size() != 3 || obs[0].idx != 0 ||
        obs[0].a !== tbl[0].dev_addr || done !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_rerun got to%b n%0d d%b want to0 n3 d1",
        to, obs.size(), done);
    end
  endtask

  task automatic test_back_to_back();
    bit hit;
    rand_table();
    set_plan(0, 0, 0);
    obs.delete();
    @(negedge clk) go = 1;
    hit = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done) begin
        hit = 1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!hit || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart got hit%b d%b b%b want 1 0 1",
        hit, done, busy);
    end
    hit = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done) begin
        hit = 1;
        break;
      end
    end
    go = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (!hit || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got hit%b d%b b%b want 1 1 0",
        hit, done, busy);
    end
    checks++;
    if (obs.size() != 2 * NCMD) begin
      failures++;
      $display("FAIL b2b_pulses got %0d want %0d",
        obs.size(), 2 * NCMD);
    end
    for (int i = 0; i < 2 * NCMD; i++) begin
      checks++;
      if (i >= obs.size() || obs[i].idx != i % NCMD ||
          obs[i].d !== tbl[i % NCMD].reg_data) begin
        failures++;
        $display("FAIL b2b_cmd%0d got idx%0d want idx%0d", i,
          (i < obs.size()) ? obs[i].idx : -1, i % NCMD);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++)
      test_scenario("random",
        int'($urandom_range(0, 4)),
        int'($urandom_range(0, 4)),
        int'($urandom_range(0, 4)), 0);
  endtask

  initial begin
    rand_table();
    set_plan(0, 0, 0);
    test_reset();
    test_all_ack();
    test_scenario("nack_once", 0, 1, 0, 0);
    test_scenario("nack_always", 0, 0, NEVER, 0);
    test_scenario("stuck_finish", NEVER, 0, 0, 1);
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
